// File: rtl/pad_turnaround_ctrl.sv
// Direction sequencer for a bank of bidirectional pads sharing one OE/IE pair.
// Arbitrates RX (default) vs TX bursts with programmable dead cycles between directions.
module pad_turnaround_ctrl #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned TURN_CYCLES = 2,
  parameter logic [1:0]  DS_RESET    = 2'b01,
  parameter logic        SR_RESET    = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_wr,
  input  logic [1:0]       cfg_ds,
  input  logic             cfg_sr,
  output logic             cfg_ready,
  input  logic             tx_req,
  output logic             tx_gnt,
  input  logic             tx_valid,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_last,
  output logic             tx_ready,
  input  logic             rx_en,
  output logic             rx_valid,
  output logic [WIDTH-1:0] rx_data,
  output logic [WIDTH-1:0] pad_a,
  output logic             pad_oe,
  output logic             pad_ie,
  output logic             pad_ds0,
  output logic             pad_ds1,
  output logic             pad_sr,
  input  logic [WIDTH-1:0] pad_y
);

  typedef enum logic [1:0] {
    ST_RX      = 2'd0,
    ST_PRE_TX  = 2'd1,
    ST_TX      = 2'd2,
    ST_POST_TX = 2'd3
  } state_t;

  localparam logic [3:0] TURN_LOAD = 4'(TURN_CYCLES - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       beat;

  assign beat = (state == ST_TX) && tx_valid && tx_ready;

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      ST_RX: begin
        if (tx_req) begin
          state_nxt = ST_PRE_TX;
          cnt_nxt   = TURN_LOAD;
        end
      end
      ST_PRE_TX: begin
        if (cnt == 4'd0) state_nxt = ST_TX;
        else             cnt_nxt   = cnt - 4'd1;
      end
      ST_TX: begin
        if (beat && tx_last) begin
          state_nxt = ST_POST_TX;
          cnt_nxt   = TURN_LOAD;
        end
      end
      ST_POST_TX: begin
        if (cnt == 4'd0) state_nxt = ST_RX;
        else             cnt_nxt   = cnt - 4'd1;
      end
      default: state_nxt = ST_RX;
    endcase
  end

  // Pad controls are decoded from the next state and registered, so OE/IE never glitch.
  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_RX;
      cnt       <= 4'd0;
      pad_oe    <= 1'b0;
      pad_ie    <= 1'b1;
      tx_gnt    <= 1'b0;
      tx_ready  <= 1'b0;
      cfg_ready <= 1'b1;
      pad_a     <= '0;
      pad_ds1   <= DS_RESET[1];
      pad_ds0   <= DS_RESET[0];
      pad_sr    <= SR_RESET;
      rx_valid  <= 1'b0;
      rx_data   <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      pad_oe    <= (state_nxt == ST_TX);
      pad_ie    <= (state_nxt == ST_RX);
      tx_gnt    <= (state_nxt == ST_TX);
      tx_ready  <= (state_nxt == ST_TX);
      cfg_ready <= (state_nxt == ST_RX);

      if (state_nxt == ST_RX && state != ST_RX) pad_a <= '0;
      else if (beat)                            pad_a <= tx_data;

      if (cfg_wr && cfg_ready) begin
        pad_ds1 <= cfg_ds[1];
        pad_ds0 <= cfg_ds[0];
        pad_sr  <= cfg_sr;
      end

      // Pads are only sampled while the receivers are enabled.
      rx_valid <= (state == ST_RX) && rx_en;
      if ((state == ST_RX) && rx_en) rx_data <= pad_y;
    end
  end

endmodule
